// File: rtl/line_buffer_reader_if.sv
// Bus between line_buffer_reader and its neighbours: line announcement, capture-RAM read port
// and the pixel stream. The reader drives through the master modport.
interface line_buffer_reader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11
);
    logic              line_ready;
    logic              line_bank;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              busy;
    logic              overrun;

    modport master (
        input  line_ready, line_bank, q, pix_ready,
        output rdaddress, pix_data, pix_valid, pix_last, busy, overrun
    );

    modport slave (
        output line_ready, line_bank, q, pix_ready,
        input  rdaddress, pix_data, pix_valid, pix_last, busy, overrun
    );
endinterface

// File: rtl/line_buffer_reader.sv
// Streams one captured line out of a two-bank RAM as a ready/valid pixel stream, with a
// 2-entry output FIFO and room for one queued line request.
module line_buffer_reader #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned LINE_LEN = 640
) (
    input logic                  clock,
    input logic                  rst_n,
    line_buffer_reader_if.master bus
);

    localparam int unsigned CntW = $clog2(LINE_LEN + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(LINE_LEN - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic              fifo_last_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        occ_q;
    logic              pending_q;
    logic              pending_bank_q;
    logic              overrun_q;

    logic              pop;
    logic              issue;
    logic              issue_last;
    logic              last_xfer;
    logic              take_pending;
    logic [2:0]        demand;
    logic [ADDR_W-1:0] issue_addr;

    function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
        return bank ? ADDR_W'(LINE_LEN) : '0;
    endfunction

    always_comb begin
        pop          = (occ_q != 2'd0) && bus.pix_ready;
        // The slot freed by a same-cycle pop counts as free, so reads run at 1/cycle.
        demand       = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
        issue        = (state_q == StRead) && (demand < 3'd2);
        issue_addr   = base_q + ADDR_W'(cnt_q);
        issue_last   = (cnt_q == LastIdx);
        last_xfer    = pop && fifo_last_q[rd_ptr_q];
        take_pending = (state_q == StDrain) && last_xfer && pending_q;
    end

    assign bus.rdaddress = issue ? issue_addr : last_addr_q;
    assign bus.pix_valid = (occ_q != 2'd0);
    assign bus.pix_data  = fifo_data_q[rd_ptr_q];
    assign bus.pix_last  = (occ_q != 2'd0) && fifo_last_q[rd_ptr_q];
    assign bus.busy      = (state_q != StIdle);
    assign bus.overrun   = overrun_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            base_q          <= '0;
            cnt_q           <= '0;
            last_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            occ_q           <= 2'd0;
            pending_q       <= 1'b0;
            pending_bank_q  <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            overrun_q       <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            occ_q           <= occ_q + {1'b0, inflight_q} - {1'b0, pop};

            // q belongs to the read issued on the previous edge
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= bus.q;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            case (state_q)
                StIdle: begin
                    if (bus.line_ready) begin
                        state_q <= StRead;
                        base_q  <= bank_base(bus.line_bank);
                        cnt_q   <= '0;
                    end
                end
                StRead: begin
                    if (issue) begin
                        last_addr_q <= issue_addr;
                        cnt_q       <= cnt_q + CntW'(1);
                        if (issue_last) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (last_xfer) begin
                        if (pending_q) begin
                            state_q <= StRead;
                            base_q  <= bank_base(pending_bank_q);
                            cnt_q   <= '0;
                        end else if (bus.line_ready) begin
                            state_q <= StRead;
                            base_q  <= bank_base(bus.line_bank);
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A request arriving as the line ends without a queued one starts directly above.
            if (take_pending) begin
                pending_q      <= bus.line_ready;
                pending_bank_q <= bus.line_bank;
            end else if (bus.line_ready && (state_q != StIdle) &&
                         !((state_q == StDrain) && last_xfer)) begin
                if (!pending_q) begin
                    pending_q      <= 1'b1;
                    pending_bank_q <= bus.line_bank;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

endmodule
